// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a small byte FIFO
module uart_rx_deser #(
    parameter int BIT_CYCLES = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd,
    output logic                        rx_valid,
    output logic [7:0]                  rx_data,
    output logic                        rx_perr,
    input  logic                        rx_ready,
    output logic                        frame_err,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LAST = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] HALF = 16'(BIT_CYCLES / 2 - 1);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;
    logic          rxd_m, rxd_s;
    state_t        state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift_reg, shift_n;
    logic          push, ferr_n;
    logic [7:0]    mem_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, full, wr_ok;
`ifdef UART_RX_PARITY_EN
    logic          perr, perr_n;
    logic          mem_perr [FIFO_DEPTH];
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Receiver state and bit-timing registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr      <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            perr      <= perr_n;
`endif
        end
    end

    // Frame sequencing: start is qualified at half a bit, later bits are sampled one full bit apart
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        push      = 1'b0;
        ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n    = perr;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd_s) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    shift_n[bit_idx] = rxd_s;
                    cnt_n            = '0;
                    bit_idx_n        = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_n = PARITY;
`else
                    if (bit_idx == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == LAST) begin
                    perr_n  = rxd_s ^ (^shift_reg);
                    cnt_n   = '0;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    push    = rxd_s;
                    ferr_n  = !rxd_s;
                    state_n = rxd_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rxd_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // A full FIFO still takes a push when the head leaves in the same cycle
    always_comb begin
        pop   = rx_valid && rx_ready;
        full  = count == (AW + 1)'(FIFO_DEPTH);
        wr_ok = push && (!full || pop);
    end

    // Byte FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
`ifdef UART_RX_PARITY_EN
                mem_perr[i] <= 1'b0;
`endif
            end
        end else begin
            overrun <= push && !wr_ok;
            if (wr_ok) begin
                mem_data[wr_ptr] <= shift_reg;
`ifdef UART_RX_PARITY_EN
                mem_perr[wr_ptr] <= perr;
`endif
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= (wr_ok && !pop) ? count + (AW + 1)'(1) :
                     (!wr_ok && pop) ? count - (AW + 1)'(1) : count;
        end
    end

    // Head entry is presented combinationally
    always_comb begin
        rx_valid   = count != '0;
        rx_data    = mem_data[rd_ptr];
        fifo_count = count;
`ifdef UART_RX_PARITY_EN
        rx_perr    = mem_perr[rd_ptr];
`else
        rx_perr    = 1'b0;
`endif
    end
endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Synthesizable UART receive deserializer: the receiving end of the serial frame the subsystem UART transmits on port_txd (start bit, 8 data bits LSB first, optional even parity, 1 stop bit).
- Sits between a pad-side serial input and a byte consumer: samples mid-bit, checks parity and stop bit, and buffers bytes in a small FIFO with a valid/ready output.
- Used on-chip and as a self-checking loopback receiver in subsystem tests.

Parameters:
- BIT_CYCLES, 868, clk cycles per bit (100 MHz / 115200 baud); legal range 4..65535.
- FIFO_DEPTH, 4, byte FIFO entries; power of 2, 2..16.

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous active-high reset
- rxd  input  1  asynchronous serial line, idle high
- rx_valid  output  1  FIFO head valid
- rx_data  output  8  FIFO head byte
- rx_perr  output  1  parity error flag stored with the head byte
- rx_ready  input  1  consumer accepts head when rx_valid && rx_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: byte dropped because FIFO full
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Input sync: rxd passes through 2 flops; both reset to 1. rxd_s is the second flop. Line-to-FSM latency is 2 cycles.
- Reset values: all outputs 0; state IDLE; counters 0; FIFO empty. Reset asserted mid-frame aborts the frame with no push and no error pulse.
- Bit counter cnt is 16 bits; bit_idx is 3 bits.
- IDLE: rxd_s==0 -> START, cnt=0.
- START: cnt increments. At cnt==BIT_CYCLES/2-1 (integer division), sample rxd_s:
  - 0 -> DATA, cnt=0, bit_idx=0.
  - 1 -> IDLE (glitch rejected, no error).
- DATA: at cnt==BIT_CYCLES-1, shift_reg[bit_idx]=rxd_s, cnt=0. After bit_idx==7 -> PARITY if enabled, else STOP.
- PARITY: at cnt==BIT_CYCLES-1, perr = rxd_s ^ (^shift_reg) (even parity), cnt=0 -> STOP.
- STOP: at cnt==BIT_CYCLES-1, sample rxd_s:
  - 1 -> push {perr, shift_reg}, -> IDLE.
  - 0 -> frame_err=1 for that cycle, no push, -> WAIT_IDLE.
- WAIT_IDLE: stay until rxd_s==1, then -> IDLE. Break conditions produce exactly one frame_err.
- FIFO: read and write pointers wrap modulo FIFO_DEPTH. rx_data and rx_perr are driven combinationally from the head entry.
  - Pop when rx_valid && rx_ready.
  - Push into a full FIFO: drop the byte and pulse overrun, unless a pop occurs in the same cycle; then the push is accepted and the count is unchanged.
  - Simultaneous push and pop on an empty FIFO: no pop; the push is accepted and count becomes 1.
- Push latency: the byte is visible on rx_valid the cycle after the stop-bit sample.

Optional Feature:
- UART_RX_PARITY_EN defined: PARITY state present. Frame = 11 bit times; rx_perr reports even-parity mismatch.
- Not defined: PARITY state removed. Frame = 10 bit times; rx_perr is tied 0 and no parity storage is built.

Test Plan (all with BIT_CYCLES=16, FIFO_DEPTH=4, parity enabled unless stated):
- Frame 0xA5, even parity 0, stop 1, rx_ready=1 -> rx_valid pulses with rx_data=0xA5, rx_perr=0; no frame_err or overrun.
- Frame 0x01 with parity bit 0 (wrong) -> rx_data=0x01, rx_perr=1.
- Frame 0x3C with stop bit 0, line held low for 40 cycles -> exactly one frame_err pulse, no push; next valid frame 0x55 is received correctly.
- rx_ready=0, send 5 frames 0x10..0x14 -> fifo_count=4, one overrun on the 5th; then rx_ready=1 pops 0x10, 0x11, 0x12, 0x13 in order.
- 5-cycle low glitch on idle rxd -> START rejects it; no push, no errors, state returns to IDLE.
- rst asserted during DATA of 0xFF, released, then frame 0x81 sent -> only 0x81 received; fifo_count=1. With UART_RX_PARITY_EN undefined, a 10-bit frame 0x81 is also received with rx_perr=0.
